// File: rtl/turn_pkg.sv
// Shared types and constants for the turn arbiter.
package turn_pkg;

  localparam int MARK_EMPTY = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  typedef logic [3:0] bcd_t;

  // Constant-only helper: converts an elaboration-time integer (0..99) to
  // two packed BCD digits {tens, ones}. Never used on runtime data.
  function automatic logic [7:0] to_bcd2(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with reload and "last second" detect.
module bcd_down_counter
  import turn_pkg::*;
#(
  parameter int INIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output bcd_t o_tens,
  output bcd_t o_ones,
  output logic o_last
);

  localparam logic [7:0] INIT_BCD = to_bcd2(INIT);

  bcd_t r_tens;
  bcd_t r_ones;

  // Reload wins over decrement; ones digit borrows 0->9 from tens.
  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      {r_tens, r_ones} <= INIT_BCD;
    end else if (i_dec) begin
      if (r_ones == 4'd0) begin
        r_ones <= 4'd9;
        r_tens <= r_tens - 4'd1;
      end else begin
        r_ones <= r_ones - 4'd1;
      end
    end
  end

  assign o_tens = r_tens;
  assign o_ones = r_ones;
  // Value 01: the next decrement would reach zero, so the owner reloads instead.
  assign o_last = (r_tens == 4'd0) && (r_ones == 4'd1);

endmodule

// File: rtl/turn_arbiter.sv
// Turn arbiter: validates cell requests, rotates players, per-turn timer.
module turn_arbiter
  import turn_pkg::*;
#(
  parameter int BOARD_CELLS   = 9,
  parameter int LOC_W         = 4,
  parameter int MARK_W        = 2,
  parameter int NUM_PLAYERS   = 2,
  parameter int TICKS_PER_SEC = 100,
  parameter int TURN_SECONDS  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          key_valid,
  input  logic [LOC_W-1:0]              key_code,
  input  logic [BOARD_CELLS*MARK_W-1:0] board,
  input  logic                          pause,
  output logic                          move_valid,
  output logic [LOC_W-1:0]              move_loc,
  output logic [MARK_W-1:0]             move_mark,
  output logic [$clog2(NUM_PLAYERS)-1:0] whos_turn,
  output logic                          illegal,
  output logic                          timeout,
  output logic [3:0]                    time_tens,
  output logic [3:0]                    time_ones
);

  localparam int TW   = $clog2(NUM_PLAYERS);
  localparam int PS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(TICKS_PER_SEC - 1);
  localparam logic [TW-1:0]   TURN_LAST = TW'(NUM_PLAYERS - 1);

  if (TURN_SECONDS > 99 || TURN_SECONDS < 1) begin : g_bad_turn
    $error("turn_arbiter: TURN_SECONDS must be 1..99");
  end
  if (NUM_PLAYERS > (2 ** MARK_W) - 1 || NUM_PLAYERS < 2) begin : g_bad_players
    $error("turn_arbiter: NUM_PLAYERS must be 2..2^MARK_W-1");
  end
  if (BOARD_CELLS > (2 ** LOC_W) || BOARD_CELLS < 1) begin : g_bad_cells
    $error("turn_arbiter: BOARD_CELLS must be 1..2^LOC_W");
  end

  state_t            r_state, w_state_nxt;
  logic [PS_W-1:0]   r_presc;
  logic [TW-1:0]     r_turn;
  logic [LOC_W-1:0]  r_loc;
  logic [MARK_W-1:0] r_mark;
  logic              r_move_valid, r_illegal, r_timeout;

  logic w_run, w_tick, w_last, w_in_range, w_cell_empty;
  logic w_accept, w_reject, w_timeout, w_illegal, w_advance;
  bcd_t w_tens, w_ones;

  // Pause handling: state flips one cycle after pause changes.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic for RUN/HOLD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (pause)  w_state_nxt = ST_HOLD;
      ST_HOLD: if (!pause) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Decode the requested cell from the live board; out-of-range codes never match.
  always_comb begin
    w_in_range   = 1'b0;
    w_cell_empty = 1'b0;
    for (int i = 0; i < BOARD_CELLS; i++) begin
      if (key_code == LOC_W'(i)) begin
        w_in_range   = 1'b1;
        w_cell_empty = (board[i*MARK_W +: MARK_W] == MARK_W'(MARK_EMPTY));
      end
    end
  end

  assign w_run     = (r_state == ST_RUN);
  assign w_tick    = w_run && (r_presc == PS_LAST);
  assign w_accept  = w_run && key_valid && w_in_range && w_cell_empty;
  assign w_reject  = w_run && key_valid && !(w_in_range && w_cell_empty);
  // A move in the final-second cycle preempts the timeout; a timeout
  // preempts a rejected key so the three pulses never overlap.
  assign w_timeout = w_tick && w_last && !w_accept;
  assign w_illegal = w_reject && !w_timeout;
  assign w_advance = w_accept || w_timeout;

  // Prescaler: counts only in RUN, restarts whenever the turn changes.
  always_ff @(posedge clk) begin
    if (rst || w_advance)  r_presc <= '0;
    else if (w_tick)       r_presc <= '0;
    else if (w_run)        r_presc <= r_presc + PS_W'(1);
  end

  // Turn rotation, last-move registers and registered event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_turn       <= '0;
      r_loc        <= '0;
      r_mark       <= '0;
      r_move_valid <= 1'b0;
      r_illegal    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_move_valid <= w_accept;
      r_illegal    <= w_illegal;
      r_timeout    <= w_timeout;
      if (w_accept) begin
        r_loc  <= key_code;
        r_mark <= MARK_W'(r_turn) + MARK_W'(1);
      end
      if (w_advance) r_turn <= (r_turn == TURN_LAST) ? '0 : r_turn + TW'(1);
    end
  end

  bcd_down_counter #(.INIT(TURN_SECONDS)) u_bcd (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_advance),
    .i_dec  (w_tick && !w_advance),
    .o_tens (w_tens),
    .o_ones (w_ones),
    .o_last (w_last)
  );

  assign move_valid = r_move_valid;
  assign move_loc   = r_loc;
  assign move_mark  = r_mark;
  assign whos_turn  = r_turn;
  assign illegal    = r_illegal;
  assign timeout    = r_timeout;
  assign time_tens  = w_tens;
  assign time_ones  = w_ones;

endmodule

// File: doc/turn_arbiter.md
TURN_ARBITER -- requirements
Module: turn_arbiter

Interface
REQ-001 SHALL provide parameter BOARD_CELLS, default 9, number of board cells (1..16).
REQ-002 SHALL provide parameter LOC_W, default 4, width of cell index (2^LOC_W >= BOARD_CELLS).
REQ-003 SHALL provide parameter MARK_W, default 2, width of one cell mark; 0 = empty.
REQ-004 SHALL provide parameter NUM_PLAYERS, default 2, range 2..2^MARK_W-1.
REQ-005 SHALL provide parameter TICKS_PER_SEC, default 100, clk cycles per second of turn time.
REQ-006 SHALL provide parameter TURN_SECONDS, default 8, per-turn limit, range 1..99.
REQ-007 clk  in  1  single system clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 key_valid  in  1  one-cycle strobe, key_code valid.
REQ-010 key_code  in  LOC_W  requested cell index.
REQ-011 board  in  BOARD_CELLS*MARK_W  flattened cell marks, cell i at bits [i*MARK_W +: MARK_W].
REQ-012 pause  in  1  freezes timer and ignores keys while high.
REQ-013 move_valid  out  1  one-cycle pulse, move accepted.
REQ-014 move_loc  out  LOC_W  cell of last accepted move, held between moves.
REQ-015 move_mark  out  MARK_W  mark of last accepted move, held between moves.
REQ-016 whos_turn  out  $clog2(NUM_PLAYERS)  current player index.
REQ-017 illegal  out  1  one-cycle pulse, key rejected.
REQ-018 timeout  out  1  one-cycle pulse, turn expired.
REQ-019 time_tens, time_ones  out  4 each  BCD seconds remaining in current turn.

Function
REQ-020 SHALL implement states RUN and HOLD; RUN->HOLD when pause=1, HOLD->RUN when pause=0, transitions take effect next cycle.
REQ-021 In RUN, a prescaler SHALL count 0..TICKS_PER_SEC-1; each wrap is one second tick.
REQ-022 On a second tick the {time_tens,time_ones} BCD counter SHALL decrement by one (ones borrow 0->9 from tens); no divider/modulo logic.
REQ-023 On a second tick with BCD value 01, SHALL pulse timeout, advance whos_turn, reload BCD to TURN_SECONDS, clear prescaler; displayed value never reaches 00.
REQ-024 In RUN, key_valid with key_code < BOARD_CELLS and addressed cell == 0 SHALL be accepted: next cycle move_valid=1, move_loc=key_code, move_mark=whos_turn+1, whos_turn advances, BCD reloads, prescaler clears.
REQ-025 In RUN, key_valid with key_code >= BOARD_CELLS or addressed cell != 0 SHALL pulse illegal next cycle; no other state change; move_loc/move_mark unchanged.
REQ-026 whos_turn SHALL advance as (whos_turn+1) mod NUM_PLAYERS.
REQ-027 Accepted move and timeout tick in the same cycle: move wins; no timeout pulse, single turn advance.
REQ-028 In HOLD: prescaler and BCD frozen, key_valid ignored (no move_valid, no illegal).
REQ-029 move_valid, illegal, timeout SHALL be mutually exclusive and registered (one-cycle latency from cause).
REQ-030 board SHALL be sampled in the same cycle as key_valid; no internal board copy.

Reset
REQ-031 On rst=1 at a clk edge: state RUN, whos_turn 0, prescaler 0, BCD = TURN_SECONDS, move_loc 0, move_mark 0, move_valid/illegal/timeout 0.
REQ-032 rst SHALL override pause, key_valid and any pending tick in the same cycle; mid-turn reset discards the turn.

Structure
REQ-033 Package turn_pkg SHALL hold MARK_EMPTY, the RUN/HOLD state enum, and BCD digit typedef.
REQ-034 Sub-module bcd_down_counter (load, dec, 2-digit BCD out, zero-detect) SHALL implement REQ-022/023 counting.
REQ-035 Elaboration SHALL fail if TURN_SECONDS > 99, NUM_PLAYERS > 2^MARK_W-1, or BOARD_CELLS > 2^LOC_W.

Verification (TICKS_PER_SEC=4, TURN_SECONDS=8, defaults otherwise)
REQ-036 Reset release, idle 32 cycles -> timeout pulse at cycle 32, whos_turn 0->1, time 08 reloaded, time shows 08..01 stepping every 4 cycles.
REQ-037 board all zero, key_valid key_code=4 -> next cycle move_valid=1, move_loc=4, move_mark=01, whos_turn=1, time=08.
REQ-038 board cell 4 = 10, key_code=4; then key_code=12 -> illegal pulse each, whos_turn/time/move_loc unchanged.
REQ-039 Legal key_valid in the cycle of the final tick at time 01 -> move_valid only, no timeout, whos_turn advances once, time=08.
REQ-040 pause=1 for 20 cycles at time 05 with key_valid pulses -> time stays 05, no pulses; pause=0 resumes countdown from 05.
REQ-041 NUM_PLAYERS=3, TURN_SECONDS=12 -> three timeouts cycle whos_turn 0,1,2,0; time shows 12,11,...,10,09 with correct BCD borrow.
